circuit_sweep_driver: RTL and testbench
=======================================

// Module: circuit_sweep_driver
// PURPOSE
//  Sequential stimulus/checker wrapped around one 4-input NOR/NOT logic circuit (the DUT).
//  On start it walks the DUT inputs through all 16 combinations and waits a settle window per row.
//  It samples the DUT output through a synchroniser and rebuilds the measured truth table.
//  It then compares that table against the expected hex truth table and reports the result.
//  Sits directly upstream (drives in1..in4) and downstream (consumes out) of the circuit.
// PARAMETERS
//  TT_EXPECTED    16'h3B60  expected truth table; row k = {in1,in2,in3,in4}, expected out = TT_EXPECTED[15-k]
//  SETTLE_CYCLES  4         cycles per row before sampling; legal range 3..255 (covers 2-flop sync)
//  CNT_W          8         settle counter width; must satisfy 2**CNT_W > SETTLE_CYCLES
// PORTS
//  clk               in   1   single clock, rising edge
//  rst_n             in   1   asynchronous active-low reset
//  start             in   1   level; accepted only in IDLE or DONE
//  abort             in   1   level; cancels a sweep in progress
//  dut_out           in   1   DUT output, asynchronous to clk
//  in1,in2,in3,in4   out  1   registered DUT inputs; in1 = row MSB
//  busy              out  1   high from the cycle after start is accepted until done
//  done              out  1   one-cycle pulse when a full sweep completes
//  pass              out  1   measured_tt == TT_EXPECTED; valid when done, held until next start
//  measured_tt       out  16  rebuilt table, same bit order as TT_EXPECTED
//  mismatch_cnt      out  5   number of rows that differ (0..16)
//  first_fail_idx    out  4   lowest failing row index k
//  first_fail_valid  out  1   at least one mismatch found
// BEHAVIOUR
//  - Reset: every output 0, in1..in4 = 0, FSM in IDLE, synchroniser flops 0.
//  - FSM states: IDLE -> DRIVE -> SETTLE -> SAMPLE -> (DRIVE | FINISH) -> DONE.
//    - DRIVE: load row k onto in1..in4; stay 1 cycle.
//    - SETTLE: count SETTLE_CYCLES-1 cycles.
//    - SAMPLE: 1 cycle; capture sync'd out into measured_tt[15-k].
//    - Net cost per row = SETTLE_CYCLES+1 cycles.
//  - Row counter k runs 0..15. After the SAMPLE of k=15: FINISH computes pass.
//    Then DONE pulses done for one cycle and deasserts busy in the same cycle.
//  - Latency: done is high exactly 16*(SETTLE_CYCLES+1)+2 cycles after the edge that accepted start.
//  - Start acceptance (start high in IDLE/DONE):
//    - clears measured_tt, mismatch_cnt, first_fail_* and pass;
//    - sets busy next cycle.
//    start while busy is ignored. start held high in DONE immediately begins a new sweep.
//  - Compare per row at SAMPLE:
//    - on mismatch, mismatch_cnt increments (saturates at 16, 5-bit);
//    - first_fail_idx/valid are written only on the first mismatch.
//  - abort (any non-IDLE, non-DONE state):
//    - next state IDLE; in1..in4 -> 0; busy -> 0; done NOT pulsed; pass = 0;
//    - partial measured_tt and counters remain readable.
//    abort and start high together: abort wins; start is ignored that cycle.
//  - in1..in4 change only on DRIVE entry or abort/reset; never glitch mid-row.
//  - Asynchronous reset mid-sweep: immediate return to reset values; no done.
//  - dut_out always passes through a 2-flop synchroniser. The sample uses the second flop.
// STRUCTURE
//  - Shared package cello_sweep_pkg:
//    - sweep_state_t enum {IDLE, DRIVE, SETTLE, SAMPLE, FINISH, DONE};
//    - ROWS = 16, IDX_W = 4, function tt_bit(tt, k) returning tt[15-k].
//  - One sub-module: sweep_settle_timer.
//    - Loadable down-counter (CNT_W) with load/expire; instantiated once.
//  - The synchroniser is inline.
// TESTING
//  - Golden DUT model (TT 0x3B60), SETTLE_CYCLES=4, start pulse ->
//    done at +82 cycles, pass=1, measured_tt=16'h3B60, mismatch_cnt=0, first_fail_valid=0.
//  - DUT model with out stuck at 0 ->
//    measured_tt=0, mismatch_cnt=7, first_fail_idx=2, first_fail_valid=1, pass=0.
//  - DUT inverting row 9 only ->
//    measured_tt=16'h3B20, mismatch_cnt=1, first_fail_idx=9, pass=0.
//  - abort asserted during row 5 SETTLE ->
//    next cycle busy=0, in1..in4=0, no done pulse, pass=0.
//    A following start re-runs to pass=1.
//  - start re-pulsed while busy, and start+abort in the same cycle ->
//    sweep unaffected by the re-pulse; abort wins over start.
//  - rst_n low mid-sweep at row 12 ->
//    all outputs 0 asynchronously; after release stays IDLE until start.

Source files
------------

// File: rtl/cello_sweep_pkg.sv
// Shared types and helpers for the truth-table sweep driver.
// Row k of a table is {in1,in2,in3,in4} == k and lives at bit position 15-k.
package cello_sweep_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRIVE  = 3'd1,
    SETTLE = 3'd2,
    SAMPLE = 3'd3,
    FINISH = 3'd4,
    DONE   = 3'd5
  } sweep_state_t;

  localparam int ROWS  = 16;
  localparam int IDX_W = 4;

  function automatic logic tt_bit(input logic [ROWS-1:0] tt, input logic [IDX_W-1:0] k);
    logic [IDX_W-1:0] pos;
    pos = IDX_W'(ROWS - 1) - k;
    return tt[pos];
  endfunction

endpackage

// File: rtl/sweep_settle_timer.sv
// Loadable down-counter that marks the end of a per-row settle window.
// expire is high while the count is zero; the count parks at zero.
module sweep_settle_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             expire
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign expire = (cnt_q == '0);

endmodule

// File: rtl/circuit_sweep_driver.sv
// Walks a 4-input combinational circuit through all 16 input rows, samples its
// output through a 2-flop synchroniser and grades the rebuilt truth table.
module circuit_sweep_driver
  import cello_sweep_pkg::*;
#(
  parameter logic [15:0] TT_EXPECTED   = 16'h3B60,
  parameter int          SETTLE_CYCLES = 4,
  parameter int          CNT_W         = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic        dut_out,
  output logic        in1,
  output logic        in2,
  output logic        in3,
  output logic        in4,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] measured_tt,
  output logic [4:0]  mismatch_cnt,
  output logic [3:0]  first_fail_idx,
  output logic        first_fail_valid
);

  sweep_state_t     state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] drv_q, drv_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [ROWS-1:0]  meas_q, meas_d;
  logic [4:0]       mcnt_q, mcnt_d;
  logic [IDX_W-1:0] ffi_q, ffi_d;
  logic             ffv_q, ffv_d;
  logic             sync1_q, sync2_q;

  logic             timer_load;
  logic             timer_expire;
  logic             accept;
  logic [IDX_W-1:0] meas_pos;

  // Loaded in DRIVE, so SETTLE lasts SETTLE_CYCLES-1 cycles.
  sweep_settle_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (timer_load),
    .load_val (CNT_W'(SETTLE_CYCLES - 2)),
    .expire   (timer_expire)
  );

  assign accept   = start && !abort;
  assign meas_pos = IDX_W'(ROWS - 1) - idx_q;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    drv_d      = drv_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    pass_d     = pass_q;
    meas_d     = meas_q;
    mcnt_d     = mcnt_q;
    ffi_d      = ffi_q;
    ffv_d      = ffv_q;
    timer_load = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          state_d = DRIVE;
          idx_d   = '0;
          drv_d   = '0;
          busy_d  = 1'b1;
          pass_d  = 1'b0;
          meas_d  = '0;
          mcnt_d  = '0;
          ffi_d   = '0;
          ffv_d   = 1'b0;
        end
      end
      DRIVE: begin
        timer_load = 1'b1;
        state_d    = SETTLE;
      end
      SETTLE: begin
        if (timer_expire) state_d = SAMPLE;
      end
      SAMPLE: begin
        meas_d[meas_pos] = sync2_q;
        if (sync2_q != tt_bit(TT_EXPECTED, idx_q)) begin
          if (mcnt_q != 5'd16) mcnt_d = mcnt_q + 5'd1;
          if (!ffv_q) begin
            ffi_d = idx_q;
            ffv_d = 1'b1;
          end
        end
        if (idx_q == IDX_W'(ROWS - 1)) begin
          state_d = FINISH;
        end else begin
          idx_d   = idx_q + 1'b1;
          drv_d   = idx_q + 1'b1;
          state_d = DRIVE;
        end
      end
      FINISH: begin
        pass_d  = (meas_q == TT_EXPECTED);
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase

    // Abort drops whatever this cycle would have recorded; earlier rows stay visible.
    if (abort && (state_q inside {DRIVE, SETTLE, SAMPLE, FINISH})) begin
      state_d = IDLE;
      drv_d   = '0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      pass_d  = 1'b0;
      meas_d  = meas_q;
      mcnt_d  = mcnt_q;
      ffi_d   = ffi_q;
      ffv_d   = ffv_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      drv_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      meas_q  <= '0;
      mcnt_q  <= '0;
      ffi_q   <= '0;
      ffv_q   <= 1'b0;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      drv_q   <= drv_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      meas_q  <= meas_d;
      mcnt_q  <= mcnt_d;
      ffi_q   <= ffi_d;
      ffv_q   <= ffv_d;
      sync1_q <= dut_out;
      sync2_q <= sync1_q;
    end
  end

  assign {in1, in2, in3, in4} = drv_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign pass             = pass_q;
  assign measured_tt      = meas_q;
  assign mismatch_cnt     = mcnt_q;
  assign first_fail_idx   = ffi_q;
  assign first_fail_valid = ffv_q;

endmodule

// File: tb/tb_circuit_sweep_driver.sv
// Directed bench: a behavioural circuit model feeds dut_out; sweep results are
// queued on start and graded when done pulses.
module tb_circuit_sweep_driver;

  logic        clk = 1'b0;
  logic        rst_n, start, abort, dut_out;
  logic        in1, in2, in3, in4;
  logic        busy, done, pass;
  logic [15:0] measured_tt;
  logic [4:0]  mismatch_cnt;
  logic [3:0]  first_fail_idx;
  logic        first_fail_valid;
  logic [3:0]  row_in;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int mode  = 0;  // 0 golden, 1 output stuck at 0, 2 row 9 inverted

  typedef struct {
    logic [15:0] tt;
    logic [4:0]  cnt;
    logic [3:0]  idx;
    logic        vld;
    logic        ps;
  } exp_t;
  exp_t sb[$];

  circuit_sweep_driver #(
    .TT_EXPECTED   (16'h3B60),
    .SETTLE_CYCLES (4),
    .CNT_W         (8)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .abort            (abort),
    .dut_out          (dut_out),
    .in1              (in1),
    .in2              (in2),
    .in3              (in3),
    .in4              (in4),
    .busy             (busy),
    .done             (done),
    .pass             (pass),
    .measured_tt      (measured_tt),
    .mismatch_cnt     (mismatch_cnt),
    .first_fail_idx   (first_fail_idx),
    .first_fail_valid (first_fail_valid)
  );

  always #5 clk = ~clk;

  assign row_in = {in1, in2, in3, in4};

  function automatic logic gold_out(input logic [3:0] r);
    logic [15:0] t;
    t = 16'h3B60;
    return t[4'd15 - r];
  endfunction

  always_comb begin
    case (mode)
      1:       dut_out = 1'b0;
      2:       dut_out = gold_out(row_in) ^ (row_in == 4'd9);
      default: dut_out = gold_out(row_in);
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Cycle 1 is the cycle following the edge that accepts start.
  task automatic run_sweep(input int m, input logic [15:0] tt, input logic [4:0] cnt,
                           input logic [3:0] idx, input logic vld, input logic ps,
                           input int repulse_at);
    exp_t e;
    exp_t got;
    int   done_cyc;
    mode = m;
    e = '{tt: tt, cnt: cnt, idx: idx, vld: vld, ps: ps};
    sb.push_back(e);
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    check("busy_after_start", busy, 1);
    done_cyc = 0;
    while (done_cyc == 0 && cyc < 200) begin
      start = (cyc == repulse_at);
      tick();
      if (done) done_cyc = cyc;
    end
    start = 1'b0;
    check("done_latency", done_cyc, 82);
    got = sb.pop_front();
    check("measured_tt", measured_tt, got.tt);
    check("mismatch_cnt", mismatch_cnt, got.cnt);
    check("first_fail_idx", first_fail_idx, got.idx);
    check("first_fail_valid", first_fail_valid, got.vld);
    check("pass", pass, got.ps);
    check("busy_at_done", busy, 0);
    tick();
    check("done_one_cycle", done, 0);
    check("pass_held", pass, got.ps);
  endtask

  initial begin
    int dcount;
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_inputs", row_in, 0);
    check("rst_measured", measured_tt, 0);
    check("rst_mismatch", mismatch_cnt, 0);
    check("rst_ffvalid", first_fail_valid, 0);
    rst_n = 1'b1;
    tick();
    tick();

    run_sweep(0, 16'h3B60, 5'd0, 4'd0, 1'b0, 1'b1, 0);
    run_sweep(1, 16'h0000, 5'd7, 4'd2, 1'b1, 1'b0, 0);
    run_sweep(2, 16'h3B20, 5'd1, 4'd9, 1'b1, 1'b0, 30);

    // Abort during the settle window of row 5.
    mode = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    while (cyc < 27) tick();
    check("row5_inputs", row_in, 5);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_inputs", row_in, 0);
    check("abort_done", done, 0);
    check("abort_pass", pass, 0);
    check("abort_partial_tt", measured_tt, 16'h3800);
    dcount = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (done) dcount++;
    end
    check("abort_no_done", dcount, 0);
    check("abort_stays_idle", busy, 0);
    run_sweep(0, 16'h3B60, 5'd0, 4'd0, 1'b0, 1'b1, 0);

    // start together with abort: abort wins, both when idle and mid-sweep.
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("idle_start_abort_busy", busy, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    while (cyc < 10) tick();
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("sweep_start_abort_busy", busy, 0);
    check("sweep_start_abort_inputs", row_in, 0);
    tick();
    check("sweep_start_abort_idle", busy, 0);

    // Asynchronous reset while row 12 is being driven.
    mode = 2;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    while (cyc < 61) tick();
    check("row12_inputs", row_in, 12);
    check("row12_mismatch", mismatch_cnt, 1);
    check("row12_partial_tt", measured_tt, 16'h3B20);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_inputs", row_in, 0);
    check("arst_measured", measured_tt, 0);
    check("arst_mismatch", mismatch_cnt, 0);
    check("arst_ffidx", first_fail_idx, 0);
    check("arst_ffvalid", first_fail_valid, 0);
    #20;
    rst_n = 1'b1;
    dcount = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done || busy) dcount++;
    end
    check("arst_stays_idle", dcount, 0);
    run_sweep(0, 16'h3B60, 5'd0, 4'd0, 1'b0, 1'b1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
